// File: rtl/crc_sched_pkg.sv
// Shared types and widths for the CRC memory scrub scheduler.
package crc_sched_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT_HI,
        WR_WAIT_LO,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_HOST,
        OWN_SCRUB
    } owner_t;

endpackage

// File: rtl/crc_mem_scrub_scheduler_timer.sv
// Background scrub interval timer: raises scrub_pending every SCRUB_INTERVAL enabled cycles.
module crc_scrub_interval_timer #(
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic scrub_enable,
    input  logic scrub_grant,
    output logic scrub_pending
);

    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [CNT_W-1:0] cnt;

    // Counter is frozen while a scrub waits for the port, so intervals never stack up.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            scrub_pending <= 1'b0;
        end else begin
            if (scrub_grant)
                scrub_pending <= 1'b0;
            if (!scrub_enable) begin
                cnt <= '0;
            end else if (!scrub_pending) begin
                if (cnt == CNT_W'(SCRUB_INTERVAL - 1)) begin
                    cnt           <= '0;
                    scrub_pending <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/crc_mem_scrub_scheduler.sv
// Shares one memory command port between a host and a background CRC scrubber.
module crc_mem_scrub_scheduler
    import crc_sched_pkg::*;
#(
    parameter int SCRUB_INTERVAL  = 256,
    parameter int MAX_HOST_GRANTS = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_ack,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 host_err,
    output logic                 host_timeout,
    input  logic                 scrub_enable,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_write_busy,
    input  logic                 mem_read_busy,
    input  logic                 mem_completed,
    input  logic                 mem_data_valid,
    input  logic                 mem_error_detected,
    input  logic [DATA_W-1:0]    mem_data_out,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr,
    output logic                 scrub_pass_done,
    output logic                 timeout_flag
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GNT_W  = $clog2(MAX_HOST_GRANTS + 1);

    state_t            state, state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] scrub_addr;
    logic [GNT_W-1:0]  grant_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              scrub_pending, force_scrub, wait_tmo;
    logic              grant_host, grant_scrub;
    logic              fin_err, fin_to, op_err, op_to;

    crc_scrub_interval_timer #(
        .SCRUB_INTERVAL(SCRUB_INTERVAL)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .scrub_enable (scrub_enable),
        .scrub_grant  (grant_scrub),
        .scrub_pending(scrub_pending)
    );

    assign force_scrub     = scrub_pending && (grant_cnt == GNT_W'(MAX_HOST_GRANTS));
    assign wait_tmo        = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign mem_write       = (state == WR_ISSUE);
    assign mem_read        = (state == RD_ISSUE);
    assign host_ack        = (state == DONE) && (owner == OWN_HOST);
    assign scrub_pass_done = (state == DONE) && (owner == OWN_SCRUB) && (scrub_addr == '1);

    always_comb begin
        state_nxt   = state;
        grant_host  = 1'b0;
        grant_scrub = 1'b0;
        fin_err     = 1'b0;
        fin_to      = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_write_busy && !mem_read_busy) begin
                    if (host_req && !force_scrub) begin
                        grant_host = 1'b1;
                        state_nxt  = host_we ? WR_ISSUE : RD_ISSUE;
                    end else if (scrub_pending) begin
                        grant_scrub = 1'b1;
                        state_nxt   = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: state_nxt = WR_WAIT_HI;
            WR_WAIT_HI: begin
                if (mem_write_busy) begin
                    state_nxt = WR_WAIT_LO;
                end else if (wait_tmo) begin
                    state_nxt = DONE;
                    fin_to    = 1'b1;
                end
            end
            WR_WAIT_LO: begin
                if (!mem_write_busy) begin
                    state_nxt = DONE;
                end else if (wait_tmo) begin
                    state_nxt = DONE;
                    fin_to    = 1'b1;
                end
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (mem_completed) begin
                    state_nxt = DONE;
                    fin_err   = mem_error_detected | ~mem_data_valid;
                end else if (wait_tmo) begin
                    state_nxt = DONE;
                    fin_to    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_HOST;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            wait_cnt      <= '0;
            grant_cnt     <= '0;
            scrub_addr    <= '0;
            op_err        <= 1'b0;
            op_to         <= 1'b0;
            host_rdata    <= '0;
            host_err      <= 1'b0;
            host_timeout  <= 1'b0;
            err_count     <= '0;
            last_err_addr <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Any state change restarts the wait counter, so each wait state gets a full budget.
            wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + 1'b1;

            if (grant_host) begin
                owner     <= OWN_HOST;
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
                if (scrub_pending && grant_cnt != GNT_W'(MAX_HOST_GRANTS))
                    grant_cnt <= grant_cnt + 1'b1;
            end
            if (grant_scrub) begin
                owner     <= OWN_SCRUB;
                mem_addr  <= scrub_addr;
                mem_wdata <= '0;
                grant_cnt <= '0;
            end

            if (state != DONE && state_nxt == DONE) begin
                op_err <= fin_err;
                op_to  <= fin_to;
                if (fin_to)
                    timeout_flag <= 1'b1;
                if (owner == OWN_HOST) begin
                    host_err     <= fin_err;
                    host_timeout <= fin_to;
                    if (state == RD_WAIT && !fin_to)
                        host_rdata <= mem_data_out;
                end
            end

            // Scrub bookkeeping happens on the way out of DONE; a timed-out scrub still advances.
            if (state == DONE && owner == OWN_SCRUB) begin
                scrub_addr <= scrub_addr + 1'b1;
                if (op_err && !op_to) begin
                    last_err_addr <= scrub_addr;
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_mem_scrub_scheduler.sv
// Directed bench for crc_mem_scrub_scheduler with a small behavioural CRC memory model.
module tb_crc_mem_scrub_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_req, host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_err, host_timeout;
    logic       scrub_enable;
    logic       mem_write, mem_read;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write_busy     = 1'b0;
    logic       mem_read_busy;
    logic       mem_completed      = 1'b0;
    logic       mem_data_valid     = 1'b0;
    logic       mem_error_detected = 1'b0;
    logic [7:0] mem_data_out       = 8'h00;
    logic [7:0] err_count;
    logic [3:0] last_err_addr;
    logic       scrub_pass_done, timeout_flag;

    always #5 clk = ~clk;

    crc_mem_scrub_scheduler #(
        .SCRUB_INTERVAL (8),
        .MAX_HOST_GRANTS(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host_req          (host_req),
        .host_we           (host_we),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_ack          (host_ack),
        .host_rdata        (host_rdata),
        .host_err          (host_err),
        .host_timeout      (host_timeout),
        .scrub_enable      (scrub_enable),
        .mem_write         (mem_write),
        .mem_read          (mem_read),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_write_busy    (mem_write_busy),
        .mem_read_busy     (mem_read_busy),
        .mem_completed     (mem_completed),
        .mem_data_valid    (mem_data_valid),
        .mem_error_detected(mem_error_detected),
        .mem_data_out      (mem_data_out),
        .err_count         (err_count),
        .last_err_addr     (last_err_addr),
        .scrub_pass_done   (scrub_pass_done),
        .timeout_flag      (timeout_flag)
    );

    // Memory model: write busy 3 cycles; read busy 2 cycles then a one-cycle completed pulse.
    logic [7:0]  mem_arr [16];
    int          wcnt = 0, rcnt = 0;
    logic [3:0]  rd_addr = 4'h0;
    logic        rbusy_q = 1'b0;
    logic        force_busy, stuck;
    logic [15:0] fault_mask, invalid_mask;

    assign mem_read_busy = rbusy_q | force_busy;

    always @(posedge clk) begin
        mem_completed <= 1'b0;
        if (mem_write) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_write_busy    <= 1'b1;
            wcnt              <= 3;
        end else if (wcnt > 1) begin
            wcnt <= wcnt - 1;
        end else if (wcnt == 1) begin
            wcnt           <= 0;
            mem_write_busy <= 1'b0;
        end
        if (mem_read) begin
            rd_addr <= mem_addr;
            rbusy_q <= 1'b1;
            rcnt    <= 2;
        end else if (rcnt > 1) begin
            rcnt <= rcnt - 1;
        end else if (rcnt == 1) begin
            rcnt    <= 0;
            rbusy_q <= 1'b0;
            if (!stuck) begin
                mem_completed      <= 1'b1;
                mem_data_out       <= mem_arr[rd_addr];
                mem_error_detected <= fault_mask[rd_addr];
                mem_data_valid     <= !invalid_mask[rd_addr];
            end
        end
    end

    // Observers: command log {write, addr}, pass-done pulses, write pulse width.
    logic [4:0] op_log [$];
    int         pd_cnt = 0, mw_cycles = 0;
    logic [3:0] last_w_addr = 4'h0;
    logic [7:0] last_w_data = 8'h00;

    always @(negedge clk) begin
        if (mem_read || mem_write)
            op_log.push_back({mem_write, mem_addr});
        if (scrub_pass_done)
            pd_cnt <= pd_cnt + 1;
        if (mem_write) begin
            mw_cycles   <= mw_cycles + 1;
            last_w_addr <= mem_addr;
            last_w_data <= mem_wdata;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one host op from an IDLE cycle; lat = negedges until ack (-1 if none in budget).
    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d, output int lat);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        lat        = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = i + 1;
                break;
            end
        end
        host_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, base, mism, mw0, pd0, acks, s1, s2, nscr;
        logic seen;

        rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
        scrub_enable = 1'b0; force_busy = 1'b0; stuck = 1'b0;
        fault_mask = 16'h0000; invalid_mask = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {host_ack, host_err, host_timeout, mem_write, mem_read,
                           scrub_pass_done, timeout_flag}, 0);
        check("rst_data", {host_rdata, mem_addr, mem_wdata, err_count, last_err_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic host write/read.
        mw0 = mw_cycles;
        host_op(1'b1, 4'd5, 8'hA5, lat);
        check("wr5_ack_lat", lat, 6);
        check("wr5_timeout", host_timeout, 0);
        check("wr5_pulse_w", mw_cycles - mw0, 1);
        check("wr5_addr_data", {last_w_addr, last_w_data}, {4'd5, 8'hA5});
        host_op(1'b0, 4'd5, 8'h00, lat);
        check("rd5_lat", lat, 5);
        check("rd5_data", host_rdata, 8'hA5);
        check("rd5_err_to", {host_err, host_timeout}, 0);
        host_op(1'b1, 4'd3, 8'h3C, lat);
        host_op(1'b1, 4'd12, 8'h5A, lat);
        fault_mask = 16'h0008;
        host_op(1'b0, 4'd3, 8'h00, lat);
        check("rd3_ack", lat, 5);
        check("rd3_data", host_rdata, 8'h3C);
        check("rd3_err", host_err, 1);
        fault_mask = 16'h0000;
        host_op(1'b1, 4'd9, 8'h99, lat);
        check("wr9_rdata_held", host_rdata, 8'h3C);
        check("wr9_err_clear", host_err, 0);
        check("host_err_no_log", err_count, 0);

        // Reset in the middle of a read.
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd5;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {host_ack, mem_read, mem_write, mem_addr, host_rdata}, 0);
        rst = 1'b0; host_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (host_ack) acks++;
        end
        check("midrst_no_ack", acks, 0);
        host_op(1'b0, 4'd5, 8'h00, lat);
        check("midrst_reread", host_rdata, 8'hA5);

        // One full scrub pass with errors at 2,4,5,15 and invalid data at 9.
        base = op_log.size(); pd0 = pd_cnt;
        fault_mask = 16'h8034; invalid_mask = 16'h0200; scrub_enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (scrub_pass_done) seen = 1'b1;
        end
        scrub_enable = 1'b0;
        check("pass_done_seen", seen, 1);
        check("pass_reads", op_log.size() - base, 16);
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            if (base + i >= op_log.size()) mism++;
            else if (op_log[base + i] !== {1'b0, 4'(i)}) mism++;
        end
        check("pass_order", mism, 0);
        repeat (3) @(negedge clk);
        fault_mask = 16'h0000; invalid_mask = 16'h0000;
        check("pass_err_count", err_count, 5);
        check("pass_last_err", last_err_addr, 15);
        check("pass_done_once", pd_cnt - pd0, 1);
        repeat (40) @(negedge clk);

        // Host hogging the port while a scrub is pending.
        force_busy = 1'b1; scrub_enable = 1'b1;
        repeat (12) @(negedge clk);
        base = op_log.size();
        host_we = 1'b0; host_addr = 4'd12; host_req = 1'b1; force_busy = 1'b0;
        repeat (120) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (host_ack) break;
            @(negedge clk);
        end
        host_req = 1'b0; scrub_enable = 1'b0;
        s1 = -1; s2 = -1; nscr = 0; mism = 0;
        for (int i = base; i < op_log.size(); i++) begin
            if (op_log[i][4]) mism++;
            if (op_log[i][3:0] != 4'd12) begin
                if (nscr == 0) s1 = i - base;
                else if (nscr == 1) s2 = i - base;
                nscr++;
            end
        end
        check("arb_all_reads", mism, 0);
        check("arb_first_scrub_slot", s1, 4);
        if (s1 >= 0) check("arb_scrub_addr", op_log[base + s1][3:0], 0);
        else check("arb_scrub_addr", 32'hFFFF_FFFF, 0);
        check("arb_second_scrub_slot", s2, 10);
        repeat (40) @(negedge clk);
        check("arb_rdata", host_rdata, 8'h5A);

        // Completion never arrives.
        stuck = 1'b1;
        host_op(1'b0, 4'd5, 8'h00, lat);
        check("tmo_lat", lat, 66);
        check("tmo_flags", {host_timeout, host_err, timeout_flag}, 3'b101);
        check("tmo_rdata_held", host_rdata, 8'h5A);
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        host_op(1'b0, 4'd5, 8'h00, lat);
        check("post_tmo_read", {host_rdata, host_timeout}, {8'hA5, 1'b0});
        check("tmo_sticky", timeout_flag, 1);

        // Error counter saturation.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_clears_tmo", {timeout_flag, err_count}, 0);
        fault_mask = 16'hFFFF; scrub_enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (err_count == 8'd255) seen = 1'b1;
        end
        check("sat_reached", seen, 1);
        repeat (40) @(negedge clk);
        check("sat_hold", err_count, 8'd255);
        scrub_enable = 1'b0;
        repeat (30) @(negedge clk);
        check("sat_hold_end", err_count, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_mem_scrub_scheduler.md
Name: crc_mem_scrub_scheduler

Overview:
Sequencer and arbiter in front of crc_code_faulty_memory. It shares the memory's single write/read command port between an external host and an internal background scrubber. The scrubber periodically reads every address and logs any CRC errors. The block drives the memory's write/read pulses and holds addr/data stable for the whole operation. It tracks completion from the memory's busy/completed flags and guards every operation with a timeout.

Parameters:
SCRUB_INTERVAL, 256, idle cycles between scrub reads while scrub_enable=1 (min 1)
MAX_HOST_GRANTS, 4, consecutive host grants allowed while a scrub is pending before the scrub is forced
TIMEOUT_CYCLES, 64, max wait cycles in any wait state before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
host_req  in  1  level request; addr/we/wdata held stable until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  4  host address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  8  read data, valid in ack cycle, held until next host ack
host_err  out  1  CRC error on host read, qualified by host_ack
host_timeout  out  1  operation aborted, qualified by host_ack
scrub_enable  in  1  enables background scrubbing
mem_write  out  1  to memory write (one-cycle pulse)
mem_read  out  1  to memory read (one-cycle pulse)
mem_addr  out  4  to memory addr_in
mem_wdata  out  8  to memory data_in
mem_write_busy  in  1  from memory
mem_read_busy  in  1  from memory
mem_completed  in  1  from memory decoder completed
mem_data_valid  in  1  from memory
mem_error_detected  in  1  from memory
mem_data_out  in  8  from memory
err_count  out  8  saturating count of scrub-detected CRC errors
last_err_addr  out  4  address of most recent scrub error
scrub_pass_done  out  1  one-cycle pulse when scrub address wraps 15->0
timeout_flag  out  1  sticky; set on any timeout; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs=0. scrub_addr=0, interval counter=0, grant counter=0. Reset mid-operation aborts with no ack.
- Interval counter: counts while scrub_enable=1 and no scrub is pending. At SCRUB_INTERVAL-1 it sets scrub_pending and resets to 0. scrub_enable=0 clears the counter; an already-pending scrub stays pending.
- States: IDLE, WR_ISSUE, WR_WAIT_HI, WR_WAIT_LO, RD_ISSUE, RD_WAIT, DONE.
- IDLE: grants only when mem_write_busy=0 and mem_read_busy=0.
  - Host wins if host_req=1, unless scrub_pending=1 and grant_cnt=MAX_HOST_GRANTS; then the scrub wins.
  - Otherwise a pending scrub is granted.
  - A host grant increments grant_cnt (saturating) only while scrub_pending=1. A scrub grant clears grant_cnt and scrub_pending.
  - Grant latches owner, addr and wdata into mem_addr/mem_wdata. The scrubber always reads scrub_addr.
  - Next state is WR_ISSUE (host_we=1) or RD_ISSUE.
- WR_ISSUE: mem_write=1 for exactly one cycle, then WR_WAIT_HI.
- WR_WAIT_HI: wait for mem_write_busy=1, then WR_WAIT_LO.
- WR_WAIT_LO: wait for mem_write_busy=0, then DONE.
- RD_ISSUE: mem_read=1 for one cycle, then RD_WAIT.
- RD_WAIT: on mem_completed=1, capture mem_data_out and err = mem_error_detected | ~mem_data_valid, then go to DONE.
- mem_addr and mem_wdata are held constant from grant until the return to IDLE.
- Timeout: a wait counter is cleared on entry to each wait state. Reaching TIMEOUT_CYCLES sets timeout_flag and goes to DONE with the timeout marker set.
- DONE: one cycle, then IDLE.
  - Host owner: host_ack=1; host_rdata/host_err/host_timeout updated (host_rdata unchanged on a write).
  - Scrub owner:
    - err=1 and no timeout: err_count+1 (saturates at 255) and last_err_addr=scrub_addr.
    - scrub_addr increments mod 16; wrap 15->0 pulses scrub_pass_done.
    - A scrub timeout still advances scrub_addr.
- Minimum host read latency: grant edge to ack is 3 cycles plus the memory read latency.
- host_req dropped before ack is a protocol violation; the operation still completes.

Decomposition:
- Package crc_sched_pkg: state enum, owner encoding (OWN_HOST/OWN_SCRUB), ADDR_W=4, DATA_W=8, ERR_CNT_W=8.
- One sub-module, crc_scrub_interval_timer: holds the interval counter and scrub_pending set/clear logic.
- Arbiter, FSM and error log stay in the top.

Test Plan:
- Host write addr 5 data 0xA5, then read addr 5, fault_enable=0 -> two host_ack pulses; read gives host_rdata=0xA5, host_err=0, mem_write high exactly 1 cycle.
- scrub_enable=1, SCRUB_INTERVAL=8, fault_enable=1 on memory with burst length 2 -> all 16 addresses scrubbed in order; err_count increments per flagged read; last_err_addr=15 at pass end; scrub_pass_done pulses once.
- Host holds host_req continuously while a scrub is pending -> exactly MAX_HOST_GRANTS=4 host acks, then one scrub read, then host resumes; grant_cnt resets.
- Memory model with mem_completed stuck 0 -> host_ack after TIMEOUT_CYCLES=64 wait cycles with host_timeout=1; timeout_flag sticky.
- rst asserted during RD_WAIT -> next cycle all outputs 0, state IDLE, no host_ack; a subsequent read of a previously written address succeeds.
- err_count preloaded to 255 by 255 forced errors, then one more error -> err_count stays 255.
